// File: rtl/tetris_pkg.sv
// Event codes shared between the tetris engine and its input front end,
// plus the fixed-priority pick used to drain the pending-event mask.
package tetris_pkg;

  typedef enum logic [3:0] {
    NOEVENT    = 4'd0,
    LEFT       = 4'd1,
    RIGHT      = 4'd2,
    DOWN       = 4'd3,
    DROP       = 4'd4,
    HOLD       = 4'd5,
    ROTATE     = 4'd6,
    ROTATE_REV = 4'd7,
    BAR        = 4'd8
  } control_type;

  localparam int NUM_EVT    = 9;
  localparam int FIFO_DEPTH = 4;

  typedef logic [NUM_EVT-1:0] evt_mask_t;

  // Lowest numbered set event wins; bit 0 (NOEVENT) is never requested.
  function automatic control_type lowest_event(input evt_mask_t m);
    control_type t;
    t = NOEVENT;
    for (int k = NUM_EVT - 1; k >= 1; k--) begin
      if (m[k]) t = control_type'(k[3:0]);
    end
    return t;
  endfunction

endpackage

// File: rtl/tetris_input_debounce.sv
// Single-input debouncer: a raw level is accepted once it has been sampled
// unchanged for CYC consecutive cycles; rise/fall pulse on the accepting edge.
module input_debounce #(
  parameter int CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYC - 1);

  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          w_accept;

  assign w_accept = (r_cnt == CNT_MAX) && (r_last != r_level);

  // Reset adopts the raw level so nothing is reported when reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= i_raw;
      r_cnt   <= '0;
      r_level <= i_raw;
    end else begin
      r_last <= i_raw;
      if (i_raw != r_last) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) r_level <= r_last;
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_accept & r_last;
  assign o_fall  = w_accept & ~r_last;

endmodule

// File: rtl/tetris_input.sv
// Command source for the tetris engine: debounced buttons, auto-repeat and gravity feed a
// coalescing pending mask, a 4-deep event FIFO and a ready-paced one-cycle ctrl pulse.
module tetris_input
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int GRAVITY_CYC  = 50_000_000,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000,
  parameter int STALL_LIMIT  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [1:0] sw,
  input  logic       ready,
  output logic [3:0] ctrl,
  output logic [2:0] q_level
);

  localparam int RW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam int GW = (GRAVITY_CYC > 1) ? $clog2(GRAVITY_CYC) : 1;
  localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_PER);
  localparam logic [GW-1:0] GRAV_MAX   = GW'(GRAVITY_CYC - 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT - 1);
  localparam logic [2:0]    FIFO_FULL  = 3'(FIFO_DEPTH);

  // Raw inputs: [3:0] buttons, [4] HOLD switch, [5] gravity enable.
  logic [5:0] w_raw;
  logic [5:0] w_level;
  logic [5:0] w_rise;
  logic [5:0] w_fall;

  assign w_raw = {sw, btn};

  for (genvar gi = 0; gi < 6; gi++) begin : g_db
    input_debounce #(
      .CYC (DEBOUNCE_CYC)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (w_raw[gi]),
      .o_level (w_level[gi]),
      .o_rise  (w_rise[gi]),
      .o_fall  (w_fall[gi])
    );
  end

  logic w_unused_ok;
  assign w_unused_ok = ^{w_fall[3:0], w_fall[5], w_rise[5], w_level[4:2]};

  // Auto-repeat for LEFT/RIGHT: first fire after REPEAT_DLY held cycles, then
  // reload so the next fire lands REPEAT_PER cycles later.
  logic [1:0] w_rpt_fire;

  for (genvar gr = 0; gr < 2; gr++) begin : g_rpt
    logic [RW-1:0] r_rpt;

    assign w_rpt_fire[gr] = w_level[gr] && (r_rpt == RPT_FIRE);

    always_ff @(posedge clk) begin
      if (reset || !w_level[gr]) begin
        r_rpt <= '0;
      end else if (w_rpt_fire[gr]) begin
        r_rpt <= RPT_RELOAD;
      end else begin
        r_rpt <= r_rpt + RW'(1);
      end
    end
  end

  logic [GW-1:0] r_grav;
  logic          w_grav_fire;

  assign w_grav_fire = w_level[5] && (r_grav == GRAV_MAX);

  always_ff @(posedge clk) begin
    if (reset || !w_level[5] || w_grav_fire) begin
      r_grav <= '0;
    end else begin
      r_grav <= r_grav + GW'(1);
    end
  end

  evt_mask_t   r_pend;
  evt_mask_t   w_set;
  evt_mask_t   w_push_clr;
  control_type w_push_type;
  logic        w_push;
  logic        w_pop;

  control_type r_mem [FIFO_DEPTH];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  control_type r_ctrl;
  logic        r_holdoff;
  logic [SW-1:0] r_stall;
  logic        w_issue;

  always_comb begin
    w_set               = '0;
    w_set[int'(LEFT)]   = w_rise[0] | w_rpt_fire[0];
    w_set[int'(RIGHT)]  = w_rise[1] | w_rpt_fire[1];
    w_set[int'(ROTATE)] = w_rise[2];
    w_set[int'(DROP)]   = w_rise[3];
    w_set[int'(HOLD)]   = w_rise[4] | w_fall[4];
    w_set[int'(DOWN)]   = w_grav_fire;
  end

  always_comb begin
    w_push_type = lowest_event(r_pend);
    w_push      = (w_push_type != NOEVENT) && (r_count != FIFO_FULL);
    w_push_clr  = '0;
    if (w_push) w_push_clr[w_push_type] = 1'b1;
  end

  // A request arriving for the type being pushed this cycle stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_push_clr) | w_set;
    end
  end

  // Forced issue after a long ready-low stall lets a keypress start the engine.
  assign w_issue = (r_count != 3'd0) && (r_ctrl == NOEVENT) &&
                   ((!r_holdoff && ready) || (r_stall == STALL_MAX));
  assign w_pop   = w_issue;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_type;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= NOEVENT;
      r_holdoff <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_ctrl <= w_issue ? r_mem[r_rptr] : NOEVENT;

      if (w_issue) begin
        r_holdoff <= 1'b1;
      end else if (!ready) begin
        r_holdoff <= 1'b0;
      end

      if (w_issue || ready) begin
        r_stall <= '0;
      end else if ((r_count != 3'd0) && (r_stall != STALL_MAX)) begin
        r_stall <= r_stall + SW'(1);
      end
    end
  end

  assign ctrl    = r_ctrl;
  assign q_level = r_count;

endmodule

// File: tb/tb_tetris_input.sv
// Randomised and scenario stimulus for tetris_input, compared every cycle against
// a queue-based behavioural model of the event path.
module tb_tetris_input;

  localparam int DB = 4;
  localparam int GR = 64;
  localparam int RD = 32;
  localparam int RP = 8;
  localparam int SL = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'hF;
  logic [1:0] sw = 2'b00;
  logic       ready = 1'b1;
  logic [3:0] ctrl;
  logic [2:0] q_level;

  tetris_input #(
    .DEBOUNCE_CYC (DB),
    .GRAVITY_CYC  (GR),
    .REPEAT_DLY   (RD),
    .REPEAT_PER   (RP),
    .STALL_LIMIT  (SL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .sw      (sw),
    .ready   (ready),
    .ctrl    (ctrl),
    .q_level (q_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic     m_last [6];
  int       m_run  [6];
  logic     m_lvl  [6];
  int       m_hold [2];
  int       m_grav;
  bit [8:0] m_pend;
  int       m_fifo [$];
  int       m_ctrl;
  bit       m_armed;
  int       m_stall;

  int ev [9];
  int adj;
  int prev_ctrl;
  bit eng_ready;

  function automatic logic raw_bit(input int i);
    return (i < 4) ? btn[i] : sw[i-4];
  endfunction

  function automatic int ev_sum();
    int s;
    s = 0;
    for (int k = 1; k < 9; k++) s += ev[k];
    return s;
  endfunction

  task model_step();
    logic     acc [6];
    bit [8:0] set;
    int       pt;
    int       sz;
    bit       issue;
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        m_last[i] = raw_bit(i);
        m_lvl[i]  = raw_bit(i);
        m_run[i]  = 1;
      end
      m_hold[0] = 0;
      m_hold[1] = 0;
      m_grav    = 0;
      m_pend    = '0;
      m_fifo.delete();
      m_ctrl    = 0;
      m_armed   = 1'b1;
      m_stall   = 0;
      return;
    end
    set = '0;
    for (int i = 0; i < 6; i++) acc[i] = (m_run[i] >= DB) && (m_last[i] != m_lvl[i]);
    if (acc[0] && m_last[0]) set[1] = 1'b1;
    if (acc[1] && m_last[1]) set[2] = 1'b1;
    if (acc[2] && m_last[2]) set[6] = 1'b1;
    if (acc[3] && m_last[3]) set[4] = 1'b1;
    if (acc[4])              set[5] = 1'b1;
    // held time since acceptance decides repeats
    for (int i = 0; i < 2; i++) begin
      if (!m_lvl[i]) begin
        m_hold[i] = 0;
      end else begin
        m_hold[i]++;
        if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0))
          set[i+1] = 1'b1;
      end
    end
    if (!m_lvl[5]) begin
      m_grav = 0;
    end else begin
      m_grav++;
      if (m_grav == GR) begin
        m_grav = 0;
        set[3] = 1'b1;
      end
    end
    pt = 0;
    for (int k = 1; k <= 8; k++) begin
      if (m_pend[k]) begin
        pt = k;
        break;
      end
    end
    sz    = m_fifo.size();
    issue = (sz > 0) && (m_ctrl == 0) && ((m_armed && ready) || (m_stall == SL - 1));
    if (issue || ready) m_stall = 0;
    else if (sz > 0 && m_stall < SL - 1) m_stall++;
    if (issue) m_ctrl = m_fifo.pop_front();
    else m_ctrl = 0;
    if (pt != 0 && sz < 4) begin
      m_fifo.push_back(pt);
      m_pend[pt] = 1'b0;
    end
    m_pend = m_pend | set;
    if (issue) m_armed = 1'b0;
    else if (!ready) m_armed = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (acc[i]) m_lvl[i] = m_last[i];
      if (raw_bit(i) == m_last[i]) begin
        if (m_run[i] < DB) m_run[i]++;
      end else begin
        m_run[i] = 1;
      end
      m_last[i] = raw_bit(i);
    end
  endtask

  task step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("ctrl", int'(ctrl), m_ctrl);
    check_eq("q_level", int'(q_level), m_fifo.size());
    if (ctrl != 4'd0) begin
      if (ctrl < 4'd9) ev[ctrl]++;
      if (prev_ctrl != 0) adj++;
    end
    prev_ctrl = int'(ctrl);
    if (eng_ready) ready = (ctrl == 4'd0);
  endtask

  task run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int base;
    int base2;
    for (int k = 0; k < 9; k++) ev[k] = 0;
    adj       = 0;
    prev_ctrl = 0;
    eng_ready = 1'b0;

    // reset with all buttons down, keep them held afterwards
    reset = 1'b1; btn = 4'hF; sw = 2'b00; ready = 1'b1;
    run(3);
    reset = 1'b0;
    run(20);
    btn = 4'h0;
    run(10);
    check_eq("held_after_reset", ev_sum(), 0);

    // bouncing LEFT press
    btn[0] = 1'b1; step();
    btn[0] = 1'b0; step();
    btn[0] = 1'b1; step();
    btn[0] = 1'b0; step();
    btn[0] = 1'b1;
    run(20);
    check_eq("bounce_left", ev[1], 1);
    check_eq("bounce_only", ev_sum(), 1);
    btn[0] = 1'b0;
    run(12);
    ready = 1'b0; step();
    ready = 1'b1;

    // LEFT and ROTATE together, ready toggling
    base  = ev[1];
    base2 = ev[6];
    btn = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      ready = (i % 2 == 0);
      step();
    end
    btn = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      ready = (i % 2 == 0);
      step();
    end
    check_eq("pair_left", ev[1] - base, 1);
    check_eq("pair_rotate", ev[6] - base2, 1);

    // RIGHT held: press plus four repeats, engine-like ready
    eng_ready = 1'b1;
    ready = 1'b1;
    base = ev[2];
    btn = 4'b0010;
    run(60);
    btn = 4'b0000;
    run(20);
    check_eq("repeat_right", ev[2] - base, 5);

    // gravity
    base = ev[3];
    sw = 2'b10;
    run(210);
    check_eq("gravity_on", ev[3] - base, 3);
    base = ev[3];
    sw = 2'b00;
    run(150);
    check_eq("gravity_off", ev[3] - base, 0);

    // ready stuck low: forced issue
    eng_ready = 1'b0;
    ready = 1'b0;
    base = ev[4];
    btn = 4'b1000;
    run(10);
    btn = 4'b0000;
    run(30);
    check_eq("forced_drop", ev[4] - base, 1);

    // five distinct events at once fill the FIFO
    base = ev_sum();
    btn = 4'hF;
    sw  = 2'b01;
    run(12);
    check_eq("q_sat", int'(q_level), 4);
    btn = 4'h0;
    run(110);
    check_eq("drain_forced", ev_sum() - base, 5);

    // randomised traffic with occasional mid-run reset
    ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        int b;
        b = int'($urandom_range(0, 3));
        btn[b] = ~btn[b];
      end
      if ($urandom_range(0, 39) == 0) begin
        int s;
        s = int'($urandom_range(0, 1));
        sw[s] = ~sw[s];
      end
      ready = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    run(40);
    check_eq("no_adjacent", adj, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
